// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle main control unit
// Sequences fetch/decode/execute/memory/writeback and drives all datapath selects.
module mc_control_fsm #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_source,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   instr_done,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   illegal_op,
  output logic [3:0]             state_out
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       decode_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = S_FETCH;
    decode_illegal = 1'b0;
    case (state)
      S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = S_EXECUTE;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          OP_ADDI:       next_state = S_ADDI_EX;
          default: begin
            next_state     = S_FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   next_state = S_R_WB;
      S_ADDI_EX:   next_state = S_ADDI_WB;
      default:     next_state = S_FETCH;
    endcase
  end

  // IR/PC loads in FETCH are suppressed while reset is held so no write strobe leaks out.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready & ~rst;
        pc_write  = mem_ready & ~rst;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      if (instr_done) instr_count <= instr_count + COUNT_WIDTH'(1);
      if (state == S_DECODE && decode_illegal) illegal_op <= 1'b1;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized self-checking bench for mc_control_fsm
// Expected behaviour comes from per-opcode step plans and the per-step control table.
module tb_mc_control_fsm;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0]    pc_source, alu_src_b, alu_op;
  logic [CW-1:0] instr_count;
  logic [3:0]    state_out;
  logic [16:0]   ctrl;

  int total = 0;
  int bad   = 0;
  int m_count;
  bit m_ill;
  int cyc;

  mc_control_fsm #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .instr_count(instr_count), .illegal_op(illegal_op),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, instr_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] exp_ctrl(input int ph, input bit rdy);
    logic pw, pwc, ior, mr, mw, irw, m2r, rd, rw, asa, dn;
    logic [1:0] ps, asb, aop;
    {pw, pwc, ior, mr, mw, irw, m2r, rd, rw, asa, dn} = '0;
    ps = 2'b00; asb = 2'b00; aop = 2'b00;
    case (ph)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; ior = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; ior = 1; dn = rdy; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      9:  begin pw = 1; ps = 2'b10; dn = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, ps, ior, mr, mw, irw, m2r, rd, rw, asa, asb, aop, dn};
  endfunction

  // One instruction: walk its step plan; wait steps stall fs/ms cycles (or randomly if rnd).
  task automatic run_instr(input logic [5:0] op, input bit rnd, input int fs, input int ms,
                           output int ncyc);
    int  plan[$];
    bit  legal, rdy, waits, done;
    int  stalls;
    legal = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    case (op)
      6'h00:   plan = {0, 1, 6, 7};
      6'h23:   plan = {0, 1, 2, 3, 4};
      6'h2B:   plan = {0, 1, 2, 5};
      6'h04:   plan = {0, 1, 8};
      6'h02:   plan = {0, 1, 9};
      6'h08:   plan = {0, 1, 10, 11};
      default: plan = {0, 1};
    endcase
    ncyc = 0;
    foreach (plan[k]) begin
      stalls = 0;
      while (1) begin
        @(negedge clk);
        opcode = op;
        waits = (plan[k] == 0) || (plan[k] == 3) || (plan[k] == 5);
        if (!waits)   rdy = 1'($urandom_range(0, 1));
        else if (rnd) rdy = ($urandom_range(0, 3) != 0) || (stalls >= 4);
        else          rdy = stalls >= ((plan[k] == 0) ? fs : ms);
        mem_ready = rdy;
        #1;
        ncyc++;
        check("state", state_out, plan[k]);
        check("ctrl", ctrl, exp_ctrl(plan[k], rdy));
        check("count", instr_count, m_count);
        check("illegal", illegal_op, m_ill);
        done = (plan[k] inside {4, 7, 8, 9, 11}) || (plan[k] == 5 && rdy);
        @(posedge clk);
        if (done) m_count = (m_count + 1) % (1 << CW);
        if (plan[k] == 1 && !legal) m_ill = 1'b1;
        if (!waits || rdy) break;
        stalls++;
      end
    end
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_count = 0;
    m_ill   = 1'b0;
  endtask

  initial begin
    logic [5:0] seq_ops[6];
    int         seq_cyc[6];
    logic [5:0] pool[8];
    seq_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    seq_cyc = '{4, 5, 4, 3, 3, 4};
    pool    = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h01};

    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
    m_count = 0; m_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_out, 0);
    check("rst_count", instr_count, 0);
    check("rst_ill", illegal_op, 0);
    mem_ready = 1'b1;
    #1;
    check("rst_ctrl_rdy", ctrl, exp_ctrl(0, 1'b0));
    rst = 1'b0;

    foreach (seq_ops[i]) begin
      run_instr(seq_ops[i], 1'b0, 0, 0, cyc);
      check("seq_cycles", cyc, seq_cyc[i]);
    end
    #1;
    check("seq_count6", instr_count, 6);

    run_instr(6'h23, 1'b0, 3, 2, cyc);
    check("lw_stall_cycles", cyc, 10);
    run_instr(6'h2B, 1'b0, 0, 2, cyc);
    check("sw_stall_cycles", cyc, 6);

    run_instr(6'h3F, 1'b0, 0, 0, cyc);
    check("illegal_cycles", cyc, 2);
    #1;
    check("illegal_set", illegal_op, 1);
    check("illegal_nocount", instr_count, 8);
    run_instr(6'h00, 1'b0, 0, 0, cyc);
    #1;
    check("illegal_sticky", illegal_op, 1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : pool[$urandom_range(0, 7)];
      run_instr(op, 1'b1, 0, 0, cyc);
    end

    #1;
    mem_ready = 1'b1; opcode = 6'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_exec", state_out, 6);
    rst = 1'b1;
    #1;
    check("mid_rst_state", state_out, 0);
    check("mid_rst_count", instr_count, 0);
    check("mid_rst_ill", illegal_op, 0);
    check("mid_rst_ctrl", ctrl, exp_ctrl(0, 1'b0));
    m_count = 0; m_ill = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(6'h00, 1'b0, 0, 0, cyc);
    check("post_rst_cycles", cyc, 4);

    do_reset();
    repeat (17) run_instr(6'h02, 1'b0, 0, 0, cyc);
    #1;
    check("wrap_count", instr_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
